// File: rtl/armaria_seq_pkg.sv
`default_nettype none
// armaria_seq_pkg: phase/state encodings, instruction classes and the id-to-class decode
// used by phase_sequencer.  Rev 1.0
package armaria_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM      = 3'd3,
    ST_IOWAIT   = 3'd4,
    ST_WB       = 3'd5,
    ST_HALT     = 3'd6,
    ST_STEPWAIT = 3'd7
  } seq_state_e;

  typedef enum logic [3:0] {
    CL_NOP      = 4'd0,
    CL_ALU      = 4'd1,
    CL_LOAD     = 4'd2,
    CL_STORE    = 4'd3,
    CL_OUT      = 4'd4,
    CL_IN       = 4'd5,
    CL_BRANCH_C = 4'd6,
    CL_JUMP     = 4'd7,
    CL_HALT     = 4'd8
  } instr_class_e;

  localparam logic [6:0] ID_ALU_A_LO  = 7'd1;
  localparam logic [6:0] ID_ALU_A_HI  = 7'd37;
  localparam logic [6:0] ID_BRC_A     = 7'd38;
  localparam logic [6:0] ID_LOAD_A    = 7'd39;
  localparam logic [6:0] ID_STORE_LO  = 7'd40;
  localparam logic [6:0] ID_STORE_HI  = 7'd42;
  localparam logic [6:0] ID_LOAD_LO   = 7'd43;
  localparam logic [6:0] ID_LOAD_HI   = 7'd47;
  localparam logic [6:0] ID_LS_ALT_LO = 7'd48;
  localparam logic [6:0] ID_LS_ALT_HI = 7'd55;
  localparam logic [6:0] ID_ALU_B_LO  = 7'd56;
  localparam logic [6:0] ID_ALU_B_HI  = 7'd66;
  localparam logic [6:0] ID_STORE_B   = 7'd67;
  localparam logic [6:0] ID_LOAD_B    = 7'd68;
  localparam logic [6:0] ID_OUT_LO    = 7'd69;
  localparam logic [6:0] ID_OUT_HI    = 7'd70;
  localparam logic [6:0] ID_IN        = 7'd71;
  localparam logic [6:0] ID_JUMP      = 7'd72;
  localparam logic [6:0] ID_BRC_B     = 7'd73;
  localparam logic [6:0] ID_NOP       = 7'd74;
  localparam logic [6:0] ID_HALT      = 7'd75;

  function automatic instr_class_e classify(input logic [6:0] id);
    instr_class_e c;
    c = CL_NOP;
    case (id) inside
      [ID_ALU_A_LO:ID_ALU_A_HI], [ID_ALU_B_LO:ID_ALU_B_HI]: c = CL_ALU;
      ID_LOAD_A, [ID_LOAD_LO:ID_LOAD_HI], ID_LOAD_B:        c = CL_LOAD;
      [ID_STORE_LO:ID_STORE_HI], ID_STORE_B:                c = CL_STORE;
      // 48..55 interleave: even ids store, odd ids load
      [ID_LS_ALT_LO:ID_LS_ALT_HI]:                          c = id[0] ? CL_LOAD : CL_STORE;
      [ID_OUT_LO:ID_OUT_HI]:                                c = CL_OUT;
      ID_IN:                                                c = CL_IN;
      ID_BRC_A, ID_BRC_B:                                   c = CL_BRANCH_C;
      ID_JUMP:                                              c = CL_JUMP;
      ID_HALT:                                              c = CL_HALT;
      ID_NOP:                                               c = CL_NOP;
      default:                                              c = CL_NOP;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// phase_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/IOWAIT/WB sequencer gating the ARMAria
// datapath strobes. Define ARMARIA_SINGLE_STEP_EN for a step input and STEPWAIT state.  Rev 1.0
module phase_sequencer
  import armaria_seq_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int PHASE_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [6:0]         id,
  input  logic               take,
  input  logic               io_ack,
`ifdef ARMARIA_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               ir_load,
  output logic               pc_write,
  output logic               pc_src,
  output logic               rb_write,
  output logic               mem_write,
  output logic               io_strobe,
  output logic               io_wait,
  output logic               halted,
  output logic [PHASE_W-1:0] phase
);

  localparam int               CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MEM_LAT - 1);

  seq_state_e       state_q, state_d;
  instr_class_e     class_q, class_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ir_load_q, ir_load_d, pc_write_q, pc_write_d, rb_write_q, rb_write_d;
  logic mem_write_q, mem_write_d, io_strobe_q, io_strobe_d;
  logic io_wait_q, io_wait_d, halted_q, halted_d;
`ifdef ARMARIA_SINGLE_STEP_EN
  logic seen_low_q, seen_low_d;
`endif

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    cnt_d   = cnt_q;
`ifdef ARMARIA_SINGLE_STEP_EN
    seen_low_d = seen_low_q;
`endif
    case (state_q)
      // FETCH exits only after the ir_load cycle has actually been issued, which also
      // covers MEM_LAT==1 straight out of reset (outputs are forced low there).
      ST_FETCH: begin
        if (ir_load_q) begin
          state_d = ST_DECODE;
          cnt_d   = '0;
        end else if (cnt_q != LAST) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DECODE: begin
        class_d = classify(id);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        cnt_d = '0;
        case (class_q)
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_IN:             state_d = ST_IOWAIT;
          CL_HALT:           state_d = ST_HALT;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (cnt_q == LAST) begin
          state_d = ST_WB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_IOWAIT: begin
        if (io_ack) state_d = ST_WB;
      end
      ST_WB: begin
        cnt_d = '0;
`ifdef ARMARIA_SINGLE_STEP_EN
        state_d    = ST_STEPWAIT;
        seen_low_d = 1'b0;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_HALT: state_d = ST_HALT;
`ifdef ARMARIA_SINGLE_STEP_EN
      ST_STEPWAIT: begin
        if (!step)           seen_low_d = 1'b1;
        else if (seen_low_q) state_d    = ST_FETCH;
      end
`endif
      default: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
    endcase

    // Moore strobes decoded from the next state so they register glitch-free
    ir_load_d   = (state_d == ST_FETCH) && (cnt_d == LAST);
    mem_write_d = (state_d == ST_MEM) && (class_d == CL_STORE);
    io_wait_d   = (state_d == ST_IOWAIT);
    pc_write_d  = (state_d == ST_WB);
    rb_write_d  = (state_d == ST_WB) && (class_d inside {CL_ALU, CL_LOAD, CL_IN});
    io_strobe_d = (state_d == ST_WB) && (class_d == CL_OUT);
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      class_q     <= CL_NOP;
      cnt_q       <= '0;
      ir_load_q   <= 1'b0;
      pc_write_q  <= 1'b0;
      rb_write_q  <= 1'b0;
      mem_write_q <= 1'b0;
      io_strobe_q <= 1'b0;
      io_wait_q   <= 1'b0;
      halted_q    <= 1'b0;
`ifdef ARMARIA_SINGLE_STEP_EN
      seen_low_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      cnt_q       <= cnt_d;
      ir_load_q   <= ir_load_d;
      pc_write_q  <= pc_write_d;
      rb_write_q  <= rb_write_d;
      mem_write_q <= mem_write_d;
      io_strobe_q <= io_strobe_d;
      io_wait_q   <= io_wait_d;
      halted_q    <= halted_d;
`ifdef ARMARIA_SINGLE_STEP_EN
      seen_low_q  <= seen_low_d;
`endif
    end
  end

  // pc_src is a mux select qualified by pc_write; take is the live flag result in WB
  assign pc_src    = (state_q == ST_WB) &&
                     ((class_q == CL_JUMP) || ((class_q == CL_BRANCH_C) && take));
  assign ir_load   = ir_load_q;
  assign pc_write  = pc_write_q;
  assign rb_write  = rb_write_q;
  assign mem_write = mem_write_q;
  assign io_strobe = io_strobe_q;
  assign io_wait   = io_wait_q;
  assign halted    = halted_q;
  assign phase     = PHASE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// tb_phase_sequencer: directed and random instruction streams, each checked cycle by cycle
// against an expected phase list built from the instruction-class rules.
module tb_phase_sequencer;

  localparam int ML = 2;
  localparam int C_NOP = 0, C_ALU = 1, C_LOAD = 2, C_STORE = 3, C_OUT = 4,
                 C_IN = 5, C_BRC = 6, C_JUMP = 7, C_HALT = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] id = '0;
  logic       take = 1'b0;
  logic       io_ack = 1'b0;
  logic       ir_load, pc_write, pc_src, rb_write, mem_write, io_strobe, io_wait, halted;
  logic [2:0] phase;
  logic [10:0] obs_v;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  phase_sequencer #(.MEM_LAT(ML), .PHASE_W(3)) dut (
    .clock(clock), .reset(reset), .id(id), .take(take), .io_ack(io_ack),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .rb_write(rb_write),
    .mem_write(mem_write), .io_strobe(io_strobe), .io_wait(io_wait),
    .halted(halted), .phase(phase)
  );

  assign obs_v = {phase, ir_load, pc_write, pc_src, rb_write, mem_write, io_strobe, io_wait, halted};

  function automatic int cls_of(input int i);
    if (i inside {[1:37], [56:66]})                        return C_ALU;
    if (i inside {39, [43:47], 49, 51, 53, 55, 68})        return C_LOAD;
    if (i inside {[40:42], 48, 50, 52, 54, 67})            return C_STORE;
    if (i inside {69, 70})                                 return C_OUT;
    if (i == 71)                                           return C_IN;
    if (i inside {38, 73})                                 return C_BRC;
    if (i == 72)                                           return C_JUMP;
    if (i == 75)                                           return C_HALT;
    return C_NOP;
  endfunction

  function automatic logic [10:0] mk(input int ph, input bit il, input bit pw, input bit ps,
                                     input bit rw, input bit mw, input bit ios, input bit iow,
                                     input bit h);
    logic [2:0] p3;
    p3 = ph[2:0];
    return {p3, il, pw, ps, rw, mw, ios, iow, h};
  endfunction

  task automatic check(input logic [10:0] e, input string tag, input int k);
    n_cmp++;
    assert (obs_v === e) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, k, obs_v, e);
    end
  endtask

  // Runs one instruction; stop_after>0 truncates the cycle list (used to abort mid-instruction).
  task automatic run_instr(input int iid, input bit itake, input int n_iow,
                           input int stop_after, input string tag);
    logic [10:0] exp_q[$];
    int c, n, iow_start;
    c = cls_of(iid);
    iow_start = ML + 2;
    for (int i = 0; i < ML; i++) exp_q.push_back(mk(0, i == ML - 1, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
    if (c == C_LOAD || c == C_STORE)
      for (int i = 0; i < ML; i++) exp_q.push_back(mk(3, 0, 0, 0, 0, c == C_STORE, 0, 0, 0));
    else if (c == C_IN)
      for (int i = 0; i < n_iow; i++) exp_q.push_back(mk(4, 0, 0, 0, 0, 0, 0, 1, 0));
    if (c == C_HALT)
      for (int i = 0; i < 20; i++) exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 1));
    else
      exp_q.push_back(mk(5, 0, 1, (c == C_JUMP) || (c == C_BRC && itake),
                         (c == C_ALU) || (c == C_LOAD) || (c == C_IN), 0, c == C_OUT, 0, 0));
    n = (stop_after > 0 && stop_after < exp_q.size()) ? stop_after : exp_q.size();
    id = iid[6:0];
    take = itake;
    for (int k = 0; k < n; k++) begin
      io_ack = (c == C_IN) && (n_iow == 1 || k >= iow_start + n_iow - 1);
      #1;
      check(exp_q[k], tag, k);
      @(negedge clock);
    end
    io_ack = 1'b0;
  endtask

  task automatic do_reset(input int edges, input string tag);
    reset = 1'b0;
    io_ack = 1'b0;
    repeat (edges) @(negedge clock);
    reset = 1'b1;
    #1;
    check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), tag, 0);
  endtask

  initial begin
    int rid, rtk, rn;
    do_reset(3, "por");
    run_instr(4,  0, 1, 0, "alu4");
    run_instr(40, 0, 1, 0, "store40");
    run_instr(73, 1, 1, 0, "brc_take");
    run_instr(73, 0, 1, 0, "brc_notake");
    run_instr(72, 0, 1, 0, "jump_t0");
    run_instr(72, 1, 1, 0, "jump_t1");
    run_instr(71, 0, 10, 0, "in_wait10");
    run_instr(71, 0, 1, 0, "in_ack_on_entry");
    run_instr(39, 0, 1, 0, "load39");
    run_instr(69, 0, 1, 0, "out69");
    run_instr(0,  1, 1, 0, "nop0");
    run_instr(74, 0, 1, 0, "nop74");
    run_instr(40, 0, 1, ML + 3, "store_abort");
    #1;
    check(mk(3, 0, 0, 0, 0, 1, 0, 0, 0), "store_abort_mem", ML + 3);
    do_reset(1, "rst_in_mem");
    run_instr(75, 0, 1, 0, "halt");
    do_reset(1, "halt_rst");
    run_instr(4,  0, 1, 0, "alu_after_halt");
    for (int r = 0; r < 40; r++) begin
      rid = int'($urandom_range(0, 127));
      rtk = int'($urandom_range(0, 1));
      rn  = int'($urandom_range(1, 6));
      run_instr(rid, rtk[0], rn, 0, "random");
      if (cls_of(rid) == C_HALT) do_reset(1, "random_halt_rst");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
